vram_wr_buffer: RTL

- Host-side VRAM write staging buffer, directly upstream of the ppu h2f_vram_* write port.
- Accepts host (HPS) VRAM writes at any time via valid/ready into a FIFO.
- Drains them into the ppu only inside the ppu's write window, opened by cpu_vram_wr_irq and held open with cpu_wr_busy.
- Replaces ad-hoc IRQ-driven writers with a frame-safe, rate-decoupled path.

---
 rtl/vram_wr_buffer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/vram_wr_buffer.sv
// Host VRAM write staging FIFO that drains into the ppu write port only inside the IRQ-opened window.
// Optional macro VRAM_WR_ADDR_CHECK_EN drops pushes above VRAM_TOP and raises a sticky addr_err.
module vram_wr_buffer #(
    parameter int          DEPTH     = 64,
    parameter int          MAX_BURST = 512,
    parameter logic [12:0] VRAM_TOP  = 13'h1A27
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [12:0]              wr_addr,
    input  logic [63:0]              wr_data,
    input  logic [7:0]               wr_byteena,
    input  logic                     cpu_vram_wr_irq,
    output logic                     cpu_wr_busy,
    output logic [12:0]              h2f_vram_wraddr,
    output logic                     h2f_vram_wren,
    output logic [63:0]              h2f_vram_wrdata,
    output logic [7:0]               h2f_vram_byteena,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     addr_err,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(MAX_BURST) + 1;
    localparam int EW = 13 + 64 + 8;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    state_t        state_q;
    logic          irq_q;
    logic [SW-1:0] snap_q;
    logic          busy_q;
    logic          wren_q;
    logic [12:0]   addr_q;
    logic [63:0]   data_q;
    logic [7:0]    be_q;

    logic          push;
    logic          store;
    logic          pop;
    logic          start;
    logic          addr_bad;
    logic [SW-1:0] snap_load;
    logic [12:0]   head_addr;
    logic [63:0]   head_data;
    logic [7:0]    head_be;

    assign wr_ready = (count_q != CW'(DEPTH));
    assign push     = wr_valid && wr_ready;

`ifdef VRAM_WR_ADDR_CHECK_EN
    assign addr_bad = (wr_addr > VRAM_TOP);
`else
    assign addr_bad = 1'b0;
`endif

    // A rejected push still completes its handshake; it just never reaches the FIFO.
    assign store = push && !addr_bad;
    assign pop   = (state_q == DRAIN) && (snap_q != '0);
    assign start = cpu_vram_wr_irq && !irq_q;

    assign snap_load = (int'(count_q) > MAX_BURST) ? SW'(MAX_BURST) : SW'(count_q);

    assign {head_addr, head_data, head_be} = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= {wr_addr, wr_data, wr_byteena};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (store) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({store, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Snapshot is latched once per window so writes arriving mid-drain wait for the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            snap_q  <= '0;
            busy_q  <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
        end else begin
            irq_q <= cpu_vram_wr_irq;
            case (state_q)
                IDLE: begin
                    wren_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        busy_q  <= 1'b1;
                        snap_q  <= snap_load;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        wren_q <= 1'b1;
                        addr_q <= head_addr;
                        data_q <= head_data;
                        be_q   <= head_be;
                        snap_q <= snap_q - SW'(1);
                    end else begin
                        wren_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    wren_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef VRAM_WR_ADDR_CHECK_EN
    logic err_q;

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (push && addr_bad) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign addr_err = err_q;
`else
    logic unused_ok;
    assign unused_ok = err_clr ^ (wr_addr > VRAM_TOP);
    assign addr_err  = 1'b0;
`endif

    assign cpu_wr_busy      = busy_q;
    assign h2f_vram_wren    = wren_q;
    assign h2f_vram_wraddr  = addr_q;
    assign h2f_vram_wrdata  = data_q;
    assign h2f_vram_byteena = be_q;
    assign fifo_level       = count_q;

endmodule
